block_mux: RTL and testbench
============================

# block_mux

Serializer that splits one 64-bit cipher block into ten 7-bit chunks and writes them, one per cycle, into the write side of the outbound byte FIFO. It is the transmit-side counterpart of the FIFO-to-block collector: it sits between the block cipher output and the TX FIFO feeding the link. A block written here and read back through the collector is reproduced bit-exactly.

## Interface
- No parameters. Geometry is fixed: 64-bit block, 7 payload bits per byte, 10 bytes per block.
- clk  input  1  system clock, all logic on posedge
- rst  input  1  synchronous, active-high reset
- block  input  64  block to transmit; sampled only on accept
- block_valid  input  1  upstream has a block on `block`
- block_ready  output  1  high when the serializer can accept a block
- full  input  1  TX FIFO full flag
- data  output  8  FIFO write data
- wr_en  output  1  FIFO write enable; one byte is written per cycle it is high
- block_sent  output  1  one-cycle pulse on the cycle the tenth byte is written

## Operation
- States:
  - IDLE: `block_ready`=1.
  - SEND: `block_ready`=0.
- Accept:
  - Occurs when `block_valid && block_ready` at a posedge.
  - Registers `block` into the internal shift register `sreg`, clears the chunk counter `cnt` (4 bits), and moves to SEND.
- Chunk k (k=0..8) is `block[7k+6:7k]`. Chunk 9 is `block[63]` in bit 0, with bits 6:1 = 0.
- Implementation: `sreg` shifts right by 7 on each write; the current chunk is always `sreg[6:0]`.
- In SEND:
  - `wr_en` = !`full` (combinational).
  - `data[6:0]` = current chunk.
  - `data[7]` = 0, unless changed by the parity feature (see Configuration).
  - On each cycle with `wr_en`=1: shift `sreg`, `cnt` <= `cnt`+1.
  - On the write with `cnt`==9: `block_sent`=1 for that cycle, `cnt` <= 0, next state IDLE.
- `full` high in SEND: no write, and `sreg`/`cnt` hold. Stalls may last any number of cycles.
- In IDLE: `wr_en`=0 and `block_sent`=0. `data` is don't-care; it is driven from `sreg[6:0]`.
- `block` and `block_valid` changes during SEND are ignored; no second block is buffered.
- Reset: returns to IDLE with `sreg`=0 and `cnt`=0. A block in flight is discarded with no further writes, even when asserted mid-SEND. Bytes already written stay in the FIFO. Downstream resynchronizes at the link level.

## Timing
- Values after reset: `block_ready`=1, `wr_en`=0, `block_sent`=0, `data`=8'h00.
- Accept at edge N. The first byte can be written in the cycle after edge N, combinationally gated by `full` in that cycle.
- With `full` low throughout, the ten writes occupy ten consecutive cycles and `block_sent` coincides with the tenth.
- `block_ready` rises the cycle after the tenth write, so the minimum period is 11 cycles per block.
- `wr_en` depends combinationally on `full`. The FIFO `full` flag must be registered on the FIFO side; there is no combinational loop.
- `rst` and `block_valid` high in the same cycle: reset wins and no accept occurs.
- `full` and `rst` high together: reset wins.

## Configuration
- `BLOCK_MUX_PARITY_EN` defined: `data[7]` = ^`data[6:0]`, which gives even parity over all 8 bits. This applies to every written byte, including chunk 9.
- `BLOCK_MUX_PARITY_EN` undefined: `data[7]` = 0 on every byte. Output is compatible with a receiver that ignores bit 7.
- No other behaviour changes between the two builds.

## Test plan
- Reset, then `block`=64'hFFFF_FFFF_FFFF_FFFF with `full`=0 -> ten consecutive writes: 8'h7F ×9 then 8'h01, and `block_sent` on the tenth. With parity: 8'hFF ×9 then 8'h81.
- `block`=64'h0123_4567_89AB_CDEF, `full`=0 -> byte 0 = 8'h6F, byte 1 = 8'h1B, byte 9 = 8'h00. Feeding these bytes through the collector returns 64'h0123_4567_89AB_CDEF.
- Hold `full`=1 for 5 cycles after byte 3 -> `wr_en`=0 during the stall. Byte 4 is written with the unchanged chunk value, and the total is still 10 writes.
- Assert `block_valid` continuously with a new `block` value every cycle -> exactly one accept per 11 cycles. Each burst matches the block sampled at its accept edge.
- Assert `rst` during the write of byte 5 -> no writes after it, `block_ready`=1 on the next cycle, and no `block_sent`. A fresh block then serializes correctly starting from chunk 0.
- `rst` and `block_valid` in the same cycle -> no accept; `block_ready` stays 1 and `wr_en` stays 0.

Source files
------------

// File: rtl/block_mux.sv
`default_nettype none
// ============================================================================
// Module   : block_mux
// Brief    : Splits a 64-bit block into ten 7-bit chunks written one per cycle
//            into a byte FIFO. Define BLOCK_MUX_PARITY_EN for even parity in bit 7.
// Revision : 1.0 - initial release
// ============================================================================
module block_mux (
    input  logic        clk,
    input  logic        rst,
    input  logic [63:0] block,
    input  logic        block_valid,
    output logic        block_ready,
    input  logic        full,
    output logic [7:0]  data,
    output logic        wr_en,
    output logic        block_sent
);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_SEND = 1'b1;

    localparam logic [3:0] C_LAST_CHUNK = 4'd9;

    logic [0:0]  r_state;
    logic [0:0]  w_next_state;
    logic [63:0] r_sreg;
    logic [3:0]  r_cnt;
    logic        w_accept;
    logic        w_last;
    logic [6:0]  w_chunk;

    assign w_accept = block_valid && block_ready;
    assign w_last   = (r_cnt == C_LAST_CHUNK);
    assign w_chunk  = r_sreg[6:0];

    // State register and datapath; zero-fill on shift leaves block[63] alone in chunk 9
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_sreg  <= 64'd0;
            r_cnt   <= 4'd0;
        end else begin
            r_state <= w_next_state;
            if (w_accept) begin
                r_sreg <= block;
                r_cnt  <= 4'd0;
            end else if (wr_en) begin
                r_sreg <= {7'd0, r_sreg[63:7]};
                r_cnt  <= w_last ? 4'd0 : (r_cnt + 4'd1);
            end
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: if (block_valid) w_next_state = S_SEND;
            S_SEND: if (!full && w_last) w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    always_comb begin
        block_ready = 1'b0;
        wr_en       = 1'b0;
        block_sent  = 1'b0;
        case (r_state)
            S_IDLE: block_ready = 1'b1;
            S_SEND: begin
                wr_en      = !full;
                block_sent = !full && w_last;
            end
            default: block_ready = 1'b0;
        endcase
    end

`ifdef BLOCK_MUX_PARITY_EN
    assign data = {^w_chunk, w_chunk};
`else
    assign data = {1'b0, w_chunk};
`endif

endmodule
`default_nettype wire

// File: tb/tb_block_mux.sv
`default_nettype none
// ============================================================================
// Module   : tb_block_mux
// Brief    : Self-checking bench for block_mux: vector table, hand sequences
//            and randomized traffic against a queue-based reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_block_mux;

    logic        clk;
    logic        rst;
    logic [63:0] block;
    logic        block_valid;
    logic        block_ready;
    logic        full;
    logic [7:0]  data;
    logic        wr_en;
    logic        block_sent;

    block_mux dut (
        .clk         (clk),
        .rst         (rst),
        .block       (block),
        .block_valid (block_valid),
        .block_ready (block_ready),
        .full        (full),
        .data        (data),
        .wr_en       (wr_en),
        .block_sent  (block_sent)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: idle flag plus a queue of bytes still owed to the FIFO
    bit         m_idle = 1'b1;
    logic [7:0] m_q[$];
    int         n_acc  = 0;
    int         n_sent = 0;
    logic [7:0] log_b[0:63];
    int         log_total = 0;

    typedef struct {
        logic [63:0] blk;
        int          stall_at;
        int          stall_len;
        logic [7:0]  b0;
        logic [7:0]  b1;
        logic [7:0]  b9;
    } vec_t;

    vec_t vecs[4];

    function automatic logic [7:0] exp_byte(input logic [63:0] blk, input int k);
        logic [63:0] sh;
        logic [6:0]  ch;
        sh = blk >> (7 * k);
        ch = sh[6:0];
`ifdef BLOCK_MUX_PARITY_EN
        return {^ch, ch};
`else
        return {1'b0, ch};
`endif
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock cycle: check outputs at negedge, advance model, then return #1 after posedge
    task automatic cycle();
        bit exp_wr;
        @(negedge clk);
        exp_wr = !m_idle && !full;
        check("block_ready", {63'd0, block_ready}, {63'd0, m_idle});
        check("wr_en", {63'd0, wr_en}, {63'd0, exp_wr});
        if (exp_wr) begin
            check("data", {56'd0, data}, {56'd0, m_q[0]});
            check("block_sent", {63'd0, block_sent}, {63'd0, (m_q.size() == 1)});
            log_b[log_total % 64] = data;
            log_total++;
            if (block_sent) n_sent++;
        end else begin
            check("block_sent_idle", {63'd0, block_sent}, 64'd0);
        end
        if (rst) begin
            m_idle = 1'b1;
            m_q.delete();
        end else if (m_idle && block_valid) begin
            m_idle = 1'b0;
            n_acc++;
            for (int k = 0; k < 10; k++) m_q.push_back(exp_byte(block, k));
        end else if (exp_wr) begin
            void'(m_q.pop_front());
            if (m_q.size() == 0) m_idle = 1'b1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic run_vec(input logic [63:0] blk, input int stall_at, input int stall_len,
                           output int base);
        int stalled;
        stalled = 0;
        for (int c = 0; c < 50 && !block_ready; c++) cycle();
        base        = log_total;
        block       = blk;
        block_valid = 1'b1;
        cycle();
        block_valid = 1'b0;
        block       = {$urandom, $urandom};
        for (int c = 0; c < 100 && (log_total - base) < 10; c++) begin
            if ((log_total - base) == stall_at && stalled < stall_len) begin
                full = 1'b1;
                stalled++;
            end else begin
                full = 1'b0;
            end
            cycle();
        end
        full = 1'b0;
        check("burst_len", 64'(log_total - base), 64'd10);
    endtask

    initial begin
        int base;
        int acc0;
        int sent0;
        int log0;

`ifdef BLOCK_MUX_PARITY_EN
        vecs[0] = '{64'hFFFF_FFFF_FFFF_FFFF, -1, 0, 8'hFF, 8'hFF, 8'h81};
        vecs[3] = '{64'h8000_0000_0000_0000,  9, 3, 8'h00, 8'h00, 8'h81};
`else
        vecs[0] = '{64'hFFFF_FFFF_FFFF_FFFF, -1, 0, 8'h7F, 8'h7F, 8'h01};
        vecs[3] = '{64'h8000_0000_0000_0000,  9, 3, 8'h00, 8'h00, 8'h01};
`endif
        vecs[1] = '{64'h0123_4567_89AB_CDEF, -1, 0, 8'h6F, 8'h1B, 8'h00};
        vecs[2] = '{64'h0123_4567_89AB_CDEF,  4, 5, 8'h6F, 8'h1B, 8'h00};

        rst         = 1'b1;
        block_valid = 1'b0;
        full        = 1'b0;
        block       = 64'd0;
        @(posedge clk);
        #1;
        check("reset_data", {56'd0, data}, 64'd0);
        check("reset_ready", {63'd0, block_ready}, 64'd1);
        cycle();
        rst = 1'b0;
        cycle();

        for (int i = 0; i < 4; i++) begin
            sent0 = n_sent;
            run_vec(vecs[i].blk, vecs[i].stall_at, vecs[i].stall_len, base);
            check("vec_byte0", {56'd0, log_b[base % 64]}, {56'd0, vecs[i].b0});
            check("vec_byte1", {56'd0, log_b[(base + 1) % 64]}, {56'd0, vecs[i].b1});
            check("vec_byte9", {56'd0, log_b[(base + 9) % 64]}, {56'd0, vecs[i].b9});
            check("vec_sent", 64'(n_sent - sent0), 64'd1);
            cycle();
        end

        // Continuous valid with a new block every cycle: one accept per 11 cycles
        acc0  = n_acc;
        sent0 = n_sent;
        for (int c = 0; c < 44; c++) begin
            block       = {$urandom, $urandom};
            block_valid = 1'b1;
            cycle();
        end
        block_valid = 1'b0;
        check("stream_accepts", 64'(n_acc - acc0), 64'd4);
        check("stream_sent", 64'(n_sent - sent0), 64'd4);
        cycle();

        // Reset during the write of byte 5
        sent0       = n_sent;
        log0        = log_total;
        block       = 64'hDEAD_BEEF_CAFE_F00D;
        block_valid = 1'b1;
        cycle();
        block_valid = 1'b0;
        for (int c = 0; c < 20 && (log_total - log0) < 5; c++) cycle();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        for (int c = 0; c < 5; c++) cycle();
        check("rst_mid_writes", 64'(log_total - log0), 64'd6);
        check("rst_mid_nosent", 64'(n_sent - sent0), 64'd0);
        run_vec(64'h0123_4567_89AB_CDEF, -1, 0, base);
        check("post_rst_byte0", {56'd0, log_b[base % 64]}, 64'h6F);

        // Reset and valid together: no accept
        acc0        = n_acc;
        rst         = 1'b1;
        block_valid = 1'b1;
        block       = 64'h1111_2222_3333_4444;
        cycle();
        rst         = 1'b0;
        block_valid = 1'b0;
        cycle();
        cycle();
        check("rst_valid_noacc", 64'(n_acc - acc0), 64'd0);

        // Randomized traffic with stalls and occasional resets
        for (int c = 0; c < 600; c++) begin
            block       = {$urandom, $urandom};
            block_valid = ($urandom_range(0, 2) != 0);
            full        = ($urandom_range(0, 3) == 0);
            rst         = ($urandom_range(0, 79) == 0);
            cycle();
        end
        rst         = 1'b0;
        full        = 1'b0;
        block_valid = 1'b0;
        for (int c = 0; c < 12; c++) cycle();
        check("drain_idle", {63'd0, block_ready}, 64'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
